// File: rtl/dual_priority_encoder.sv
// ---------------------------------------------------------------------------
// dual_priority_encoder
//
// Purpose:
//   Registered dual priority encoder for request arbitration front-ends.
//   It reports the highest active request and the next-highest active
//   request. Priority follows bit index, so req[N-1] is highest and req[0] is
//   lowest. Each output is a 1-based code (bit index + 1), and 0 means no
//   request. The second code is always lower than the first unless both are 0.
//
// Configuration macro:
//   DUAL_PRIO_INREG_EN
//     Defined     : req is captured in an input register (reset to 0) before
//                   encoding. Latency from req to first/second is 2 cycles.
//     Not defined : req is encoded directly. Latency is 1 cycle.
//   Encoded results are identical in both builds.
//
// Parameters:
//   N  number of request lines (N <= 2**W - 1)
//   W  width of each encoded output code
//
// Ports:
//   clk     in   1  system clock, rising edge
//   rst_n   in   1  asynchronous active-low reset
//   req     in   N  request vector, 1 = request active
//   first   out  W  code of highest active request, 0 = none
//   second  out  W  code of second-highest active request, 0 = none
// ---------------------------------------------------------------------------
module dual_priority_encoder #(
  parameter int N = 12,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic [W-1:0] first,
  output logic [W-1:0] second
);

  logic [N-1:0] enc_in_s;
  logic [W-1:0] first_s;
  logic [W-1:0] second_s;

`ifdef DUAL_PRIO_INREG_EN
  logic [N-1:0] req_r;

  // Input capture register that adds one cycle of latency ahead of the encoder.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_r <= {N{1'b0}};
    end else begin
      req_r <= req;
    end
  end

  // The encoder operates on the registered copy of req.
  always_comb begin
    enc_in_s = req_r;
  end
`else
  // The encoder operates directly on req.
  always_comb begin
    enc_in_s = req;
  end
`endif

  // Dual encode. The scan runs from low to high index. Each active bit
  // demotes the previous leader to second place, so after the scan first
  // holds the highest active bit and second holds the next-highest one.
  always_comb begin
    first_s  = {W{1'b0}};
    second_s = {W{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (enc_in_s[i]) begin
        second_s = first_s;
        first_s  = W'(i + 1);
      end else begin
        second_s = second_s;
        first_s  = first_s;
      end
    end
  end

  // Output registers. Reset clears them asynchronously, so any in-flight
  // result is discarded at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first  <= {W{1'b0}};
      second <= {W{1'b0}};
    end else begin
      first  <= first_s;
      second <= second_s;
    end
  end

endmodule

// File: tb/tb_dual_priority_encoder.sv
// ---------------------------------------------------------------------------
// tb_dual_priority_encoder
//
// Self-checking bench for dual_priority_encoder.
// - A stimulus process drives req, computes the expected codes with a
//   reference model, and pushes each result with its due cycle into a queue.
// - A monitor process pops each entry on the cycle it falls due and compares
//   it with the DUT outputs.
// - Reset behaviour is checked directly before the scoreboard phase begins.
// ---------------------------------------------------------------------------
module tb_dual_priority_encoder;

  localparam int N = 12;
  localparam int W = 4;
`ifdef DUAL_PRIO_INREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req;
  logic [W-1:0] first;
  logic [W-1:0] second;

  typedef struct {
    logic [W-1:0] f;
    logic [W-1:0] s;
    logic [N-1:0] r;
    int           due;
  } exp_t;

  exp_t sb_q[$];
  int   cyc     = 0;
  int   nchecks = 0;
  int   nerr    = 0;

  dual_priority_encoder #(.N(N), .W(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .first  (first),
    .second (second)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: collect the active indices in descending order.
  // first is the top entry plus 1, and second is the next entry plus 1.
  function automatic void model(input logic [N-1:0] r,
                                output logic [W-1:0] f,
                                output logic [W-1:0] s);
    int act[$];
    for (int i = N - 1; i >= 0; i--) begin
      if (r[i]) act.push_back(i);
    end
    f = (act.size() > 0) ? W'(act[0] + 1) : 4'd0;
    s = (act.size() > 1) ? W'(act[1] + 1) : 4'd0;
  endfunction

  task automatic check_direct(input string name,
                              input logic [W-1:0] ef,
                              input logic [W-1:0] es);
    nchecks++;
    if (first !== ef || second !== es) begin
      nerr++;
      $display("FAIL %s: got first=%0d second=%0d, expected first=%0d second=%0d",
               name, first, second, ef, es);
    end
  endtask

  // Drive req on a falling edge and queue its expected result.
  task automatic drive(input logic [N-1:0] v);
    exp_t e;
    @(negedge clk);
    req = v;
    model(v, e.f, e.s);
    e.r   = v;
    e.due = cyc + LAT;
    sb_q.push_back(e);
  endtask

  // Monitor: every queued entry must be observed on exactly its due cycle.
  always @(negedge clk) begin
    if (rst_n && sb_q.size() > 0) begin
      if (sb_q[0].due < cyc) begin
        nchecks++;
        nerr++;
        $display("FAIL missed: req=%b due at cycle %0d, now cycle %0d",
                 sb_q[0].r, sb_q[0].due, cyc);
        void'(sb_q.pop_front());
      end else if (sb_q[0].due == cyc) begin
        nchecks++;
        if (first !== sb_q[0].f || second !== sb_q[0].s) begin
          nerr++;
          $display("FAIL encode req=%b: got first=%0d second=%0d, expected first=%0d second=%0d",
                   sb_q[0].r, first, second, sb_q[0].f, sb_q[0].s);
        end
        void'(sb_q.pop_front());
      end
    end
  end

  logic [N-1:0] pats[11];

  initial begin
    pats[0]  = 12'b100111010011;
    pats[1]  = 12'b101010101010;
    pats[2]  = 12'b001010111010;
    pats[3]  = 12'b000110101010;
    pats[4]  = 12'b000000010010;
    pats[5]  = 12'b000000000011;
    pats[6]  = 12'b000000000000;
    pats[7]  = 12'b000000000100;
    pats[8]  = 12'b100000000000;
    pats[9]  = 12'hFFF;
    pats[10] = 12'b000000000001;

    rst_n = 1'b0;
    req   = 12'h000;
    #2;
    check_direct("reset_initial", 4'd0, 4'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Load all-ones, then assert reset mid-cycle.
    req = 12'hFFF;
    repeat (LAT) @(negedge clk);
    check_direct("pre_reset_fff", 4'd12, 4'd11);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_direct("reset_immediate", 4'd0, 4'd0);
    @(posedge clk);
    #1;
    check_direct("reset_held_edge", 4'd0, 4'd0);
    @(negedge clk);
    req   = 12'h000;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_direct("reset_release", 4'd0, 4'd0);

    // Directed patterns, driven back-to-back twice.
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 11; i++) drive(pats[i]);
    end

    // Random patterns with a mix of sparse and dense vectors.
    for (int i = 0; i < 300; i++) begin
      logic [N-1:0] v;
      v = N'($urandom);
      if ($urandom_range(0, 3) == 0) v = v & N'($urandom);
      if ($urandom_range(0, 7) == 0) v = N'(1) << $urandom_range(0, N - 1);
      drive(v);
    end

    // Drain with a bounded wait.
    for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge clk);
    if (sb_q.size() > 0) begin
      nchecks++;
      nerr++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
